noc_turn_arbiter: RTL

//  Per-output-port round-robin arbiter for the router crossbar. One instance sits beside each

---
 rtl/noc_turn_arbiter_if.sv | 11 +
 rtl/noc_turn_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/noc_turn_arbiter_if.sv
// noc_turn_arbiter_if: request/grant bundle between one output port's arbiter and route logic
interface noc_turn_arbiter_if;
  logic [4:0] req;
  logic port_full;
  logic port_enable;
  logic [4:0] turn;
  logic busy;
  logic starve;
  modport master (output req, port_full, port_enable, input turn, busy, starve);
  modport slave (input req, port_full, port_enable, output turn, busy, starve);
endinterface

// File: rtl/noc_turn_arbiter.sv
// noc_turn_arbiter: per-output round-robin arbiter driving the one-hot X_turn grant
module noc_turn_arbiter #(
  parameter logic [4:0] PORT_ID = 5'b00000,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  noc_turn_arbiter_if.slave arb
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);
  state_t state, state_n;
  logic [4:0] turn, turn_n, ptr, ptr_n, rq;
  logic [CNT_W-1:0] hold, hold_n;
  logic starve, starve_n;
  // Scan order is N>S>E>W>L>N, i.e. descending bit index; p itself is checked last.
  function automatic logic [4:0] pick(input logic [4:0] p, input logic [4:0] v);
    int pi, j;
    logic [4:0] r;
    pi = 0;
    r = '0;
    for (int i = 0; i < 5; i++) if (p[i]) pi = i;
    for (int k = 5; k >= 1; k--) begin
      j = (pi + 5 - k) % 5;
      if (v[j[2:0]]) begin
        r = '0;
        r[j[2:0]] = 1'b1;
      end
    end
    return r;
  endfunction
  assign rq = arb.req & ~PORT_ID;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      turn <= '0;
      ptr <= 5'b00001;
      hold <= '0;
      starve <= 1'b0;
    end else begin
      state <= state_n;
      turn <= turn_n;
      ptr <= ptr_n;
      hold <= hold_n;
      starve <= starve_n;
    end
  end
  always_comb begin
    turn_n = turn;
    ptr_n = ptr;
    hold_n = hold;
    starve_n = 1'b0;
    if (state == IDLE) begin
      if (rq != '0) begin
        turn_n = pick(ptr, rq);
        hold_n = '0;
      end
    end else if (arb.port_enable) begin
      ptr_n = turn;
      turn_n = pick(turn, rq);
      hold_n = '0;
    end else if ((rq & turn) == '0) begin
      turn_n = pick(ptr, rq);
      hold_n = '0;
    end else if (!arb.port_full) begin
      if (hold == LAST && (rq & ~turn) != '0) begin
        ptr_n = turn;
        turn_n = pick(turn, rq & ~turn);
        hold_n = '0;
        starve_n = 1'b1;
      end else begin
        hold_n = (hold == LAST) ? hold : hold + CNT_W'(1);
      end
    end
    state_n = (turn_n != '0) ? GRANT : IDLE;
  end
  always_comb begin
    arb.turn = turn;
    arb.busy = (state == GRANT);
    arb.starve = starve;
  end
endmodule
